// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: default queue depth,
// source encodings and the codebase's boolean aliases.
package cdb_arbiter_pkg;

    localparam int   CDBDEPTH = 4;
    localparam int   CDBBW    = $clog2(CDBDEPTH);

    localparam logic SRC_EX   = 1'b0;
    localparam logic SRC_LD   = 1'b1;

    localparam logic True     = 1'b1;
    localparam logic False    = 1'b0;

endpackage

// File: rtl/cdb_fifo.sv
// Circular result queue for one CDB producer. The head entry is always
// visible on dout. A push into a full queue is ignored here; the caller
// flags the overflow. Flush empties the queue synchronously.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDBDEPTH,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [2*DW-1:0]          din,
    output logic [2*DW-1:0]          dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A full queue never accepts a push, even if the same cycle pops.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[head];

    // Storage write at the tail.
    // NOTE: the data array has no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[tail] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer queues (ALU and load path) drained
// one result per cycle onto a registered broadcast port, with round-robin
// fairness on ties, conservative next-cycle availability flags for the
// producers, a sticky overflow flag and a mispredict flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDBDEPTH,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          jump_wrong_stall,
    input  logic          ex_flag,
    input  logic [DW-1:0] ex_rob_id,
    input  logic [DW-1:0] ex_val,
    input  logic          ld_flag,
    input  logic [DW-1:0] ld_rob_id,
    input  logic [DW-1:0] ld_val,
    output logic          ex_nex_ava,
    output logic          ld_nex_ava,
    output logic          cdb_flag,
    output logic [DW-1:0] cdb_rob_id,
    output logic [DW-1:0] cdb_val,
    output logic          cdb_src,
    output logic          ovf_err
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic          ex_push, ld_push;
    logic          ex_pop, ld_pop;
    logic [2*DW-1:0] ex_head, ld_head;
    logic [AW:0]   ex_count, ld_count;
    logic          ex_full, ld_full;
    logic          ex_empty, ld_empty;
    logic          last;
    logic          grant_ex, grant_ld;
    logic          advance;

    // State only moves when enabled and not being flushed.
    assign advance = rdy & ~jump_wrong_stall;
    assign ex_push = ex_flag & advance;
    assign ld_push = ld_flag & advance;
    assign ex_pop  = grant_ex & advance;
    assign ld_pop  = grant_ld & advance;

    cdb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_ex_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (jump_wrong_stall),
        .push  (ex_push),
        .pop   (ex_pop),
        .din   ({ex_rob_id, ex_val}),
        .dout  (ex_head),
        .count (ex_count),
        .full  (ex_full),
        .empty (ex_empty)
    );

    cdb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_ld_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (jump_wrong_stall),
        .push  (ld_push),
        .pop   (ld_pop),
        .din   ({ld_rob_id, ld_val}),
        .dout  (ld_head),
        .count (ld_count),
        .full  (ld_full),
        .empty (ld_empty)
    );

    // Round-robin grant over the queue heads: a tie goes to the source that
    // did not win last time.
    // NOTE: both grants get a default first so no latch is inferred.
    always_comb begin
        grant_ex = False;
        grant_ld = False;
        if (!ex_empty && !ld_empty) begin
            grant_ex = (last == SRC_LD);
            grant_ld = (last == SRC_EX);
        end else if (!ex_empty) begin
            grant_ex = True;
        end else if (!ld_empty) begin
            grant_ld = True;
        end
    end

    // Conservative availability: assumes no pop happens this cycle.
    always_comb begin
        ex_nex_ava = (({1'b0, ex_count} + {{(AW+1){1'b0}}, ex_flag}) < DEPTH_W);
        ld_nex_ava = (({1'b0, ld_count} + {{(AW+1){1'b0}}, ld_flag}) < DEPTH_W);
    end

    // Round-robin history: remembers the source of the latest grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= SRC_LD;
        end else if (jump_wrong_stall) begin
            last <= SRC_LD;
        end else if (rdy && (grant_ex || grant_ld)) begin
            last <= grant_ld ? SRC_LD : SRC_EX;
        end
    end

    // Registered broadcast port; data holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_flag   <= False;
            cdb_rob_id <= '0;
            cdb_val    <= '0;
            cdb_src    <= SRC_EX;
        end else if (jump_wrong_stall) begin
            cdb_flag <= False;
        end else if (rdy) begin
            cdb_flag <= grant_ex | grant_ld;
            if (grant_ex) begin
                {cdb_rob_id, cdb_val} <= ex_head;
                cdb_src               <= SRC_EX;
            end else if (grant_ld) begin
                {cdb_rob_id, cdb_val} <= ld_head;
                cdb_src               <= SRC_LD;
            end
        end
    end

    // Sticky overflow: any push that lands on a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= False;
        end else if ((ex_push && ex_full) || (ld_push && ld_full)) begin
            ovf_err <= True;
        end
    end

endmodule
